// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and control-state type for the sequential ALU/register-file datapath.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SRA  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SUB  = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// `product` is the accumulator including the current partial term, valid to write when `last`.
module mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    always_comb begin
        product = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy    = busy_q;
        last    = busy_q && (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            // Only the low WIDTH product bits are kept, so the multiplicand shifts within WIDTH.
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_regfile_seq.sv
// Register file, single-cycle ALU, flags and address output, with a multi-cycle MUL
// handled by mul_seq under a two-state issue FSM.
module alu_regfile_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    localparam int unsigned RW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3:0]             opcode,
    input  logic [RW-1:0]          rd,
    input  logic [RW-1:0]          ra,
    input  logic [WIDTH-1:0]       c,
    input  logic [WIDTH-1:0]       din,
    output logic [NREGS*WIDTH-1:0] regs,
    output logic [WIDTH-1:0]       radr,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic                   ready,
    output logic                   done
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             flag_z_q, flag_c_q, done_q;
    logic [RW-1:0]    mul_rd_q;
    state_e           state_q, state_d;

    logic             issue, mul_start, mul_busy, mul_last, mul_fin;
    logic [WIDTH-1:0] op_a, op_b, alu_res, mul_product;
    logic [WIDTH:0]   sum, diff;
    logic             alu_we, alu_flags;

    assign op_a = regs_q[ra];
    assign op_b = regs_q[c[RW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (en && opcode == OP_MUL) state_d = S_MUL;
            S_MUL:  if (mul_busy && mul_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == S_IDLE);
        issue     = en && ready;
        mul_start = issue && (opcode == OP_MUL);
        mul_fin   = (state_q == S_MUL) && mul_busy && mul_last;
    end

    mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (op_a),
        .b      (op_b),
        .busy   (mul_busy),
        .last   (mul_last),
        .product(mul_product)
    );

    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, (opcode == OP_ADDI) ? c : op_b};
        diff      = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = '0;
        alu_we    = issue;
        alu_flags = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_flags = issue; end
            OP_SUB:          begin alu_res = diff[WIDTH-1:0]; alu_flags = issue; end
            OP_SRA:  alu_res = WIDTH'($signed(op_a) >>> op_b);
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_LW:   alu_res = din;
            OP_SLT:  alu_res = WIDTH'(op_a < op_b);
            OP_SLTI: alu_res = WIDTH'(op_a < c);
            OP_SLL:  alu_res = op_a << op_b;
            OP_SRL:  alu_res = op_a >> op_b;
            default: alu_we  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            mul_rd_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= mul_fin;
            if (mul_start) mul_rd_q <= rd;
            if (mul_fin) begin
                regs_q[mul_rd_q] <= mul_product;
            end else if (alu_we) begin
                regs_q[rd] <= alu_res;
            end
            if (alu_flags) begin
                // SUB reports carry as "no borrow".
                flag_c_q <= (opcode == OP_SUB) ? ~diff[WIDTH] : sum[WIDTH];
                flag_z_q <= (alu_res == '0);
            end
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < int'(NREGS); i++) regs[i*WIDTH +: WIDTH] = regs_q[i];
        flag_z = flag_z_q;
        flag_c = flag_c_q;
        done   = done_q;
        radr   = WIDTH'(1);
        if (rst) begin
            radr = '0;
        end else if (issue && (opcode == OP_LW || opcode == OP_SW || opcode == OP_JMP)) begin
            radr = op_a + c;
        end
    end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: directed scenarios plus randomized instructions checked
// against an integer-arithmetic reference model; a second 16-bit/8-register instance covers MUL.
module tb_alu_regfile_seq;

    localparam logic [3:0] O_ADDI = 4'h0, O_ADD = 4'h1, O_MUL = 4'h2, O_SRA = 4'h3;
    localparam logic [3:0] O_AND = 4'h4, O_OR = 4'h5, O_NOT = 4'h6, O_XOR = 4'h7;
    localparam logic [3:0] O_LW = 4'h8, O_SW = 4'h9, O_SLT = 4'hA, O_SLTI = 4'hB;
    localparam logic [3:0] O_SLL = 4'hC, O_SRL = 4'hD, O_SUB = 4'hE, O_JMP = 4'hF;

    logic        clk, rst, en, fz, fc, ready, done;
    logic [3:0]  opcode;
    logic [1:0]  rd, ra;
    logic [7:0]  c, din, radr;
    logic [31:0] regs;

    logic         w_en, w_fz, w_fc, w_ready, w_done;
    logic [3:0]   w_op;
    logic [2:0]   w_rd, w_ra;
    logic [15:0]  w_c, w_din, w_radr;
    logic [127:0] w_regs;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_regs [4];
    bit         m_z, m_c;

    alu_regfile_seq #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .rd(rd), .ra(ra), .c(c), .din(din),
        .regs(regs), .radr(radr), .flag_z(fz), .flag_c(fc), .ready(ready), .done(done)
    );

    alu_regfile_seq #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .rst(rst), .en(w_en), .opcode(w_op), .rd(w_rd), .ra(w_ra), .c(w_c),
        .din(w_din), .regs(w_regs), .radr(w_radr), .flag_z(w_fz), .flag_c(w_fc),
        .ready(w_ready), .done(w_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_flat();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_z = 0;
        m_c = 0;
    endfunction

    // Reference semantics from the instruction definitions, in plain integer arithmetic.
    function automatic void model_exec(logic [3:0] op, int d, int a, logic [7:0] cv,
                                       logic [7:0] dv);
        int av, bv, cvi, r, sa;
        bit wr;
        av = int'(m_regs[a]);
        cvi = int'(cv);
        bv = int'(m_regs[cvi % 4]);
        r = 0;
        wr = 1;
        case (op)
            O_ADDI: begin r = av + cvi; m_c = (r > 255); r = r % 256; m_z = (r == 0); end
            O_ADD:  begin r = av + bv;  m_c = (r > 255); r = r % 256; m_z = (r == 0); end
            O_SUB:  begin m_c = (av >= bv); r = (av - bv + 256) % 256; m_z = (r == 0); end
            O_MUL:  r = (av * bv) % 256;
            O_SRA: begin
                sa = (av >= 128) ? av - 256 : av;
                if (bv >= 8) r = (sa < 0) ? 255 : 0;
                else         r = (sa >>> bv) & 255;
            end
            O_AND:  r = av & bv;
            O_OR:   r = av | bv;
            O_NOT:  r = 255 - av;
            O_XOR:  r = av ^ bv;
            O_LW:   r = int'(dv);
            O_SLT:  r = (av < bv) ? 1 : 0;
            O_SLTI: r = (av < cvi) ? 1 : 0;
            O_SLL:  r = (bv >= 8) ? 0 : ((av << bv) & 255);
            O_SRL:  r = (bv >= 8) ? 0 : (av >> bv);
            default: wr = 0;
        endcase
        if (wr) m_regs[d] = r[7:0];
    endfunction

    task automatic issue8(input logic [3:0] op, input int d, input int a, input logic [7:0] cv,
                          input logic [7:0] dv);
        @(negedge clk);
        en = 1; opcode = op; rd = 2'(d); ra = 2'(a); c = cv; din = dv;
        @(posedge clk);
        #1 en = 0;
    endtask

    task automatic issue16(input logic [3:0] op, input int d, input int a, input logic [15:0] cv);
        @(negedge clk);
        w_en = 1; w_op = op; w_rd = 3'(d); w_ra = 3'(a); w_c = cv;
        @(posedge clk);
        #1 w_en = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        en = 1; opcode = O_LW; ra = 2'd1; c = 8'h33;
        #1;
        vectors++;
        if (regs !== 32'h0) begin miscompares++; $display("FAIL reset_regs: got %h want 0", regs); end
        vectors++;
        if ({fz, fc, ready, done} !== 4'b0010) begin
            miscompares++; $display("FAIL reset_ctl: got z,c,rdy,done=%b want 0010", {fz, fc, ready, done});
        end
        vectors++;
        if (radr !== 8'h00) begin miscompares++; $display("FAIL reset_radr: got %h want 00", radr); end
        vectors++;
        if (w_regs !== 128'h0 || w_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_wide: got rdy=%b regs=%h want 1 and 0", w_ready, w_regs);
        end
        en = 0;
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_arith();
        model_exec(O_ADDI, 1, 0, 8'h7F, 8'h00); issue8(O_ADDI, 1, 0, 8'h7F, 8'h00);
        @(negedge clk);
        vectors++;
        if ({regs[15:8], fz, fc} !== {8'h7F, 2'b00}) begin
            miscompares++; $display("FAIL addi_7f: got r1=%h z=%b c=%b want 7f 0 0", regs[15:8], fz, fc);
        end
        model_exec(O_ADD, 2, 1, 8'h01, 8'h00); issue8(O_ADD, 2, 1, 8'h01, 8'h00);
        @(negedge clk);
        vectors++;
        if ({regs[23:16], fz, fc} !== {8'hFE, 2'b00}) begin
            miscompares++; $display("FAIL add_fe: got r2=%h z=%b c=%b want fe 0 0", regs[23:16], fz, fc);
        end
        model_exec(O_ADDI, 3, 2, 8'h02, 8'h00); issue8(O_ADDI, 3, 2, 8'h02, 8'h00);
        @(negedge clk);
        vectors++;
        if ({regs[31:24], fz, fc} !== {8'h00, 2'b11}) begin
            miscompares++; $display("FAIL addi_wrap: got r3=%h z=%b c=%b want 00 1 1", regs[31:24], fz, fc);
        end
        model_exec(O_SUB, 3, 1, 8'h02, 8'h00); issue8(O_SUB, 3, 1, 8'h02, 8'h00);
        @(negedge clk);
        vectors++;
        if ({regs[31:24], fz, fc} !== {8'h81, 2'b00}) begin
            miscompares++; $display("FAIL sub_borrow: got r3=%h z=%b c=%b want 81 0 0", regs[31:24], fz, fc);
        end
        model_exec(O_SUB, 3, 2, 8'h01, 8'h00); issue8(O_SUB, 3, 2, 8'h01, 8'h00);
        @(negedge clk);
        vectors++;
        if ({regs[31:24], fz, fc} !== {8'h7F, 2'b01}) begin
            miscompares++; $display("FAIL sub_noborrow: got r3=%h z=%b c=%b want 7f 0 1", regs[31:24], fz, fc);
        end
    endtask

    task automatic test_mul();
        int low_cnt, done_cnt, done_at;
        logic [7:0] r3_old;
        logic [7:0] r3_done;
        model_exec(O_ADDI, 1, 0, 8'd7, 8'h00); issue8(O_ADDI, 1, 0, 8'd7, 8'h00);
        model_exec(O_ADDI, 2, 0, 8'd9, 8'h00); issue8(O_ADDI, 2, 0, 8'd9, 8'h00);
        r3_old = m_regs[3];
        model_exec(O_MUL, 3, 1, 8'h02, 8'h00); issue8(O_MUL, 3, 1, 8'h02, 8'h00);
        low_cnt = 0; done_cnt = 0; done_at = -1; r3_done = 8'hXX;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ready) low_cnt++;
            if (done) begin done_cnt++; done_at = i; r3_done = regs[31:24]; end
            if (i == 3) begin
                vectors++;
                if (regs[31:24] !== r3_old) begin
                    miscompares++; $display("FAIL mul_early_write: got r3=%h want %h", regs[31:24], r3_old);
                end
                en = 1; opcode = O_ADDI; rd = 2'd1; ra = 2'd0; c = 8'h55;
            end
            if (i == 4) en = 0;
        end
        vectors++;
        if (low_cnt !== 8) begin miscompares++; $display("FAIL mul_busy_len: got %0d want 8", low_cnt); end
        vectors++;
        if (done_cnt !== 1 || done_at !== 8) begin
            miscompares++; $display("FAIL mul_done: got count=%0d at=%0d want 1 at 8", done_cnt, done_at);
        end
        vectors++;
        if (r3_done !== 8'h3F) begin miscompares++; $display("FAIL mul_result: got %h want 3f", r3_done); end
        vectors++;
        if (regs !== model_flat()) begin
            miscompares++; $display("FAIL mul_dropped_en: got %h want %h", regs, model_flat());
        end
    endtask

    typedef struct {
        logic [3:0] op;
        int         d;
        int         a;
        logic [7:0] cv;
        bit         chk;
        logic [7:0] exp;
    } step_t;

    task automatic test_shifts();
        step_t tbl [9] = '{
            '{O_ADDI, 1, 0, 8'h80, 1'b0, 8'h00}, '{O_ADDI, 2, 0, 8'h03, 1'b0, 8'h00},
            '{O_SRA,  3, 1, 8'h02, 1'b1, 8'hF0}, '{O_ADDI, 2, 0, 8'h09, 1'b0, 8'h00},
            '{O_SRA,  3, 1, 8'h02, 1'b1, 8'hFF}, '{O_SRL,  3, 1, 8'h02, 1'b1, 8'h00},
            '{O_ADDI, 1, 0, 8'h81, 1'b0, 8'h00}, '{O_ADDI, 2, 0, 8'h01, 1'b0, 8'h00},
            '{O_SLL,  3, 1, 8'h02, 1'b1, 8'h02}};
        bit z_keep, c_keep;
        for (int i = 0; i < 9; i++) begin
            z_keep = m_z; c_keep = m_c;
            model_exec(tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].cv, 8'h00);
            issue8(tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].cv, 8'h00);
            @(negedge clk);
            if (tbl[i].chk) begin
                vectors++;
                if ({regs[31:24], fz, fc} !== {tbl[i].exp, z_keep, c_keep}) begin
                    miscompares++;
                    $display("FAIL shift_%0d: got r3=%h z=%b c=%b want %h %b %b", i, regs[31:24],
                             fz, fc, tbl[i].exp, z_keep, c_keep);
                end
            end
        end
    endtask

    task automatic test_mem_jmp();
        logic [3:0] ops [3] = '{O_SW, O_JMP, O_LW};
        model_exec(O_ADDI, 1, 0, 8'h10, 8'h00); issue8(O_ADDI, 1, 0, 8'h10, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1; opcode = ops[i]; rd = 2'd2; ra = 2'd1; c = 8'h05; din = 8'hA5;
            #1;
            vectors++;
            if (radr !== 8'h15) begin miscompares++; $display("FAIL radr_issue_%0d: got %h want 15", i, radr); end
            @(posedge clk);
            #1 en = 0;
            model_exec(ops[i], 2, 1, 8'h05, 8'hA5);
            @(negedge clk);
            vectors++;
            if (radr !== 8'h01 || regs !== model_flat()) begin
                miscompares++;
                $display("FAIL idle_after_%0d: got radr=%h regs=%h want 01 %h", i, radr, regs, model_flat());
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int done_cnt;
        model_exec(O_MUL, 3, 1, 8'h02, 8'h00); issue8(O_MUL, 3, 1, 8'h02, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        vectors++;
        if (radr !== 8'h00) begin miscompares++; $display("FAIL radr_in_reset: got %h want 00", radr); end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (i == 0) begin
                vectors++;
                if ({regs, fz, fc, ready} !== {32'h0, 3'b001}) begin
                    miscompares++;
                    $display("FAIL abort_state: got regs=%h z=%b c=%b rdy=%b want 0 0 0 1", regs, fz, fc, ready);
                end
            end
        end
        vectors++;
        if (done_cnt !== 0 || regs !== 32'h0) begin
            miscompares++; $display("FAIL abort_no_write: got done=%0d regs=%h want 0 0", done_cnt, regs);
        end
        model_exec(O_ADDI, 1, 0, 8'h2A, 8'h00); issue8(O_ADDI, 1, 0, 8'h2A, 8'h00);
        @(negedge clk);
        vectors++;
        if (regs !== model_flat()) begin
            miscompares++; $display("FAIL post_abort_addi: got %h want %h", regs, model_flat());
        end
    endtask

    task automatic test_wide();
        int low_cnt, done_cnt;
        logic [15:0] r7;
        issue16(O_ADDI, 1, 0, 16'd300);
        issue16(O_ADDI, 7, 0, 16'd200);
        issue16(O_MUL, 7, 1, 16'd7);
        low_cnt = 0; done_cnt = 0; r7 = 16'hXXXX;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!w_ready) low_cnt++;
            if (w_done) begin done_cnt++; r7 = w_regs[127:112]; end
        end
        vectors++;
        if (low_cnt !== 16 || done_cnt !== 1) begin
            miscompares++; $display("FAIL wide_timing: got busy=%0d done=%0d want 16 1", low_cnt, done_cnt);
        end
        vectors++;
        if (r7 !== 16'hEA60 || w_regs[31:16] !== 16'd300) begin
            miscompares++; $display("FAIL wide_mul: got r7=%h r1=%h want ea60 012c", r7, w_regs[31:16]);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] cv, dv, exp_radr;
        int d, a;
        bit seen;
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            d = $urandom_range(0, 3);
            a = $urandom_range(0, 3);
            cv = 8'($urandom);
            dv = 8'($urandom);
            if ($urandom_range(0, 2) == 0) cv = 8'($urandom_range(0, 11)); // bias toward small shifts
            exp_radr = (op == O_LW || op == O_SW || op == O_JMP) ? m_regs[a] + cv : 8'h01;
            @(negedge clk);
            en = 1; opcode = op; rd = 2'(d); ra = 2'(a); c = cv; din = dv;
            #1;
            vectors++;
            if (radr !== exp_radr) begin
                miscompares++; $display("FAIL rand_radr_%0d: got %h want %h", n, radr, exp_radr);
            end
            model_exec(op, d, a, cv, dv);
            @(posedge clk);
            #1 en = 0;
            if (op == O_MUL) begin
                seen = 0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = done;
                end
                vectors++;
                if (!seen) begin miscompares++; $display("FAIL rand_mul_timeout_%0d: got no done want done", n); end
            end else begin
                @(negedge clk);
            end
            vectors++;
            if ({regs, fz, fc} !== {model_flat(), m_z, m_c}) begin
                miscompares++;
                $display("FAIL rand_%0d op=%h: got regs=%h z=%b c=%b want %h %b %b", n, op, regs, fz, fc,
                         model_flat(), m_z, m_c);
            end
        end
    endtask

    initial begin
        clk = 0; rst = 1; en = 0; opcode = 4'h0; rd = 2'd0; ra = 2'd0; c = 8'h00; din = 8'h00;
        w_en = 0; w_op = 4'h0; w_rd = 3'd0; w_ra = 3'd0; w_c = 16'h0; w_din = 16'h0;
        model_reset();
        test_reset();
        test_arith();
        test_mul();
        test_shifts();
        test_mem_jmp();
        test_reset_mid_mul();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
